// File: rtl/pipe_pkg.sv
// Shared types, height limits and the clamp helper for the pipe-height scheduler.
package pipe_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_REQ    = 3'd2,
    S_CAP    = 3'd3,
    S_FROZEN = 3'd4
  } state_t;

  typedef logic [2:0] height_t;

  localparam height_t H_MIN = 3'd1;
  localparam height_t H_MAX = 3'd6;

  // Raw LFSR values 0 and 7 would put the gap off screen.
  function automatic height_t clamp_height(input height_t h);
    if (h < H_MIN) begin
      return H_MIN;
    end else if (h > H_MAX) begin
      return H_MAX;
    end else begin
      return h;
    end
  endfunction

endpackage

// File: rtl/pipe_fifo.sv
// Small height FIFO with synchronous flush; head value reads as 0 when empty.
module pipe_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  height_t       din,
  input  logic          pop,
  output height_t       dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   fill
);

  height_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        pop_ok;
  logic        push_ok;

  assign fill    = wr_ptr - rd_ptr;
  assign full    = (fill == (AW+1)'(DEPTH));
  assign empty   = (fill == '0);
  assign pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = empty ? height_t'(0) : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Frame-tick divider, spawn cadence FSM and LFSR sampling for pipe heights.
// Handshake: a height transfers on any rising edge where pipe_valid && pipe_ready.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int TICK_DIV  = 16,
  parameter int SPAWN_GAP = 8,
  parameter int DEPTH     = 4,
  localparam int FW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          Over,
  input  logic [2:0]    rnd_val,
  output logic          rnd_step,
  output logic          pipe_valid,
  output logic [2:0]    pipe_height,
  input  logic          pipe_ready,
  output logic          overflow,
  output logic [FW-1:0] fill,
  output logic [2:0]    state_dbg
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tick_cnt;
  logic [GW-1:0] gap_cnt;
  logic          tick_wrap;
  logic          gap_wrap;
  logic          spawn;
  logic          counting;
  logic          freeze;
  logic          restart;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  height_t       head;

  assign tick_wrap = (tick_cnt == TW'(TICK_DIV - 1));
  assign gap_wrap  = (gap_cnt == GW'(SPAWN_GAP - 1));
  assign spawn     = tick_wrap && gap_wrap;
  assign counting  = (state == S_RUN) || (state == S_REQ) || (state == S_CAP);
  assign freeze    = Over && (state != S_IDLE);
  assign restart   = start && !freeze;
  assign push      = (state == S_CAP) && !freeze && !restart;

  assign rnd_step    = (state == S_REQ);
  assign pipe_valid  = !fifo_empty && (state != S_FROZEN);
  assign pipe_height = head;
  assign pop         = pipe_valid && pipe_ready;
  assign state_dbg   = state;

  always_comb begin
    state_nx = state;
    if (freeze) begin
      state_nx = S_FROZEN;
    end else if (restart) begin
      state_nx = S_RUN;
    end else begin
      case (state)
        S_RUN:   if (spawn) state_nx = S_REQ;
        S_REQ:   state_nx = S_CAP;
        // With very short periods the next spawn can already be due here.
        S_CAP:   state_nx = spawn ? S_REQ : S_RUN;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      gap_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (restart) begin
        tick_cnt <= '0;
        gap_cnt  <= '0;
        overflow <= 1'b0;
      end else begin
        if (counting && !freeze) begin
          tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
          if (tick_wrap) gap_cnt <= gap_wrap ? '0 : gap_cnt + 1'b1;
        end
        if (push && fifo_full && !pop) overflow <= 1'b1;
      end
    end
  end

  pipe_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (restart),
    .push  (push),
    .din   (clamp_height(rnd_val)),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

endmodule

// File: tb/tb_pipe_scheduler.sv
// Randomized bench for pipe_scheduler against a cycle-count reference model.
module tb_pipe_scheduler;
  import pipe_pkg::*;

  localparam int TD = 2;
  localparam int SG = 2;
  localparam int DP = 4;
  localparam int P  = TD * SG;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       Over;
  logic [2:0] rnd_val;
  logic       rnd_step;
  logic       pipe_valid;
  logic [2:0] pipe_height;
  logic       pipe_ready;
  logic       overflow;
  logic [2:0] fill;
  logic [2:0] state_dbg;

  pipe_scheduler #(
    .TICK_DIV  (TD),
    .SPAWN_GAP (SG),
    .DEPTH     (DP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .Over        (Over),
    .rnd_val     (rnd_val),
    .rnd_step    (rnd_step),
    .pipe_valid  (pipe_valid),
    .pipe_height (pipe_height),
    .pipe_ready  (pipe_ready),
    .overflow    (overflow),
    .fill        (fill),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard: expected FIFO contents plus round bookkeeping
  logic [2:0] exp_q[$];
  bit         m_run;
  bit         m_frz;
  bit         m_ovf;
  int         m_k;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_clamp(input logic [2:0] v);
    if (v == 3'd0) return 3'd1;
    if (v == 3'd7) return 3'd6;
    return v;
  endfunction

  function automatic bit m_step_exp();
    return m_run && !m_frz && (m_k > 0) && ((m_k % P) == 0);
  endfunction

  task automatic m_restart();
    exp_q.delete();
    m_ovf = 1'b0;
    m_k   = 0;
    m_run = 1'b1;
    m_frz = 1'b0;
  endtask

  // Spawn request lands every P cycles after start; the capture is the cycle after.
  task automatic model_edge();
    bit pop;
    bit cap;
    if (!m_run) begin
      if (start) m_restart();
    end else if (m_frz) begin
      if (start && !Over) m_restart();
    end else if (Over) begin
      if (exp_q.size() > 0 && pipe_ready) void'(exp_q.pop_front());
      m_frz = 1'b1;
    end else if (start) begin
      m_restart();
    end else begin
      pop = (exp_q.size() > 0) && pipe_ready;
      cap = (m_k >= P + 1) && ((m_k % P) == 1);
      if (cap && !pop && exp_q.size() == DP) m_ovf = 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (cap && !(m_ovf && !pop && exp_q.size() == DP)) begin
        if (exp_q.size() < DP) exp_q.push_back(ref_clamp(rnd_val));
      end
      m_k++;
    end
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_rnd_step"},    8'(rnd_step),    8'(m_step_exp()));
    chk({ph, "_pipe_valid"},  8'(pipe_valid),  8'(exp_q.size() > 0 && !m_frz));
    chk({ph, "_pipe_height"}, 8'(pipe_height), exp_q.size() > 0 ? 8'(exp_q[0]) : 8'd0);
    chk({ph, "_fill"},        8'(fill),        8'(exp_q.size()));
    chk({ph, "_overflow"},    8'(overflow),    8'(m_ovf));
  endtask

  // driver: inputs are already set; advance one edge and compare
  task automatic tick(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(ph);
  endtask

  task automatic pulse_start(input string ph);
    start = 1'b1;
    tick(ph);
    start = 1'b0;
  endtask

  initial begin
    logic [2:0] vals [3];
    bit done;
    vals = '{3'd0, 3'd7, 3'd5};
    reset = 1'b0; start = 1'b0; Over = 1'b0; pipe_ready = 1'b0; rnd_val = 3'd0;
    m_run = 1'b0; m_frz = 1'b0; m_ovf = 1'b0; m_k = 0;
    #12;
    check_outputs("reset");
    chk("reset_state", 8'(state_dbg), 8'(S_IDLE));
    reset = 1'b1;
    tick("idle");

    // cadence with constant LFSR value
    pipe_ready = 1'b1; rnd_val = 3'd3;
    pulse_start("a_start");
    repeat (20) tick("a_run");

    // clamping of the extreme values
    foreach (vals[i]) begin
      rnd_val = vals[i];
      repeat (P) tick("b_clamp");
    end
    repeat (P) tick("b_tail");

    // overflow with renderer stalled, then drain
    pipe_ready = 1'b0;
    pulse_start("c_start");
    repeat (6 * P + 2) begin
      rnd_val = 3'($urandom_range(0, 7));
      tick("c_fill");
    end
    chk("c_fill_sat", 8'(fill), 8'(DP));
    chk("c_ovf_set", 8'(overflow), 8'd1);
    pipe_ready = 1'b1;
    repeat (8) tick("c_drain");

    // full FIFO with push and pop in the same capture cycle
    pipe_ready = 1'b0;
    pulse_start("d_start");
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      rnd_val = 3'($urandom_range(0, 7));
      if (exp_q.size() == DP && (m_k % P) == 1) begin
        pipe_ready = 1'b1;
        tick("d_swap");
        pipe_ready = 1'b0;
        done = 1'b1;
      end else begin
        tick("d_wait");
      end
    end
    chk("d_swap_hit", 8'(done), 8'd1);
    repeat (2) tick("d_after");
    chk("d_fill_full", 8'(fill), 8'(DP));
    chk("d_no_ovf", 8'(overflow), 8'd0);
    pipe_ready = 1'b1;
    repeat (6) tick("d_drain");

    // asynchronous reset mid-run with three entries queued
    pipe_ready = 1'b0;
    pulse_start("e_start");
    for (int n = 0; n < 40 && exp_q.size() < 3; n++) begin
      rnd_val = 3'($urandom_range(0, 7));
      tick("e_fill");
    end
    chk("e_fill3", 8'(fill), 8'd3);
    reset = 1'b0;
    #1;
    m_run = 1'b0; m_frz = 1'b0; m_ovf = 1'b0; m_k = 0; exp_q.delete();
    check_outputs("e_async");
    #2;
    reset = 1'b1;
    tick("e_idle");
    chk("e_state_idle", 8'(state_dbg), 8'(S_IDLE));

    // game over during a spawn request, then restart
    pulse_start("f_start");
    for (int n = 0; n < 40 && !(m_step_exp() && exp_q.size() >= 1); n++) begin
      rnd_val = 3'($urandom_range(0, 7));
      tick("f_pre");
    end
    chk("f_in_req", 8'(rnd_step), 8'd1);
    Over = 1'b1;
    tick("f_over");
    start = 1'b1;
    tick("f_ignored");
    start = 1'b0; Over = 1'b0;
    repeat (20) begin
      pipe_ready = 1'($urandom_range(0, 1));
      rnd_val = 3'($urandom_range(0, 7));
      tick("f_hold");
    end
    chk("f_state_frozen", 8'(state_dbg), 8'(S_FROZEN));
    pipe_ready = 1'b1;
    pulse_start("f_restart");
    repeat (12) tick("f_resume");

    // random soak
    repeat (400) begin
      pipe_ready = 1'($urandom_range(0, 3) != 0);
      rnd_val    = 3'($urandom_range(0, 7));
      start      = ($urandom_range(0, 60) == 0);
      Over       = ($urandom_range(0, 40) == 0);
      tick("g_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
